// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock,
// LSB chunk first, carry rippled through a register between chunks.
// Valid/ready handshake on operand and result sides.
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtract
    logic [WIDTH-1:0] work;
    logic             carry;

    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] s_k;
    logic             c_k;
    logic [WIDTH-1:0] work_next;
    logic             last;

    // Handshake outputs depend only on state (and reset for in_ready).
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // One narrow adder: current chunk plus rippled carry; work_next is the
    // working register with this chunk merged in, used for the final load.
    always_comb begin
        a_k        = a_r[k*CHUNK +: CHUNK];
        b_k        = b_r[k*CHUNK +: CHUNK];
        {c_k, s_k} = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
        work_next  = work;
        work_next[k*CHUNK +: CHUNK] = s_k;
        last       = (k == CNT_W'(NCHUNK - 1));
    end

    // Control FSM and datapath registers; results only change on the
    // final-chunk edge and reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            work  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= c_k;
                    k     <= last ? '0 : k + 1'b1;
                    if (last) begin
                        sum   <= work_next;
                        cout  <= c_k;
                        // Same-sign operands producing a different-sign result.
                        ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                 (work_next[WIDTH-1] != a_r[WIDTH-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder: spec vector table, hand-written
// reset/backpressure sequences, NCHUNK=1 instance, random ops vs model.
module tb_chunk_adder;
    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic          clk = 1'b0;
    logic          rst;

    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;

    logic          iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8;
    logic [7:0]    a8, b8, sum8;

    int checks = 0;
    int errors = 0;

    chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8),
        .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        bit          cin, sub;
        logic [15:0] es;
        bit          ec, eo;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  input bit c, input bit s, output longint rs,
                                  output bit rc, output bit ro);
        longint m, sa, sb, u, r;
        m  = longint'(1) << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!s) begin
            u  = ua + ub + longint'(c);
            rc = (u >= m);
            r  = sa + sb + longint'(c);
        end else begin
            u  = ua - ub - longint'(c);
            rc = (u >= 0);
            r  = sa - sb - longint'(c);
        end
        rs = ((u % m) + m) % m;
        ro = (r >= m / 2) || (r < -(m / 2));
    endfunction

    // One full operation with out_ready=1: latency, result and handshake.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input bit tc,
                         input bit ts, input logic [15:0] es, input bit ec,
                         input bit eo, input string nm);
        int cyc;
        bit ready_seen;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        cyc = 0;
        ready_seen = 1'b0;
        while (!out_valid && cyc < 20) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(N));
        chk({nm, " in_ready busy"}, 64'(ready_seen), 64'd0);
        chk({nm, " sum"}, 64'(sum), 64'(es));
        chk({nm, " cout"}, 64'(cout), 64'(ec));
        chk({nm, " ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({nm, " out_valid after"}, 64'(out_valid), 64'd0);
        chk({nm, " in_ready after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[$];
        longint rs;
        bit rc, ro;
        int cyc;
        bit flag;
        logic [15:0] ra, rb;
        bit rcn, rsb;

        vt.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add basic"});
        vt.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple wrap"});
        vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add ovf"});
        vt.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub ovf"});
        vt.push_back('{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub borrow"});
        vt.push_back('{16'h1357, 16'h0000, 1'b0, 1'b1, 16'h1357, 1'b1, 1'b0, "sub zero"});
        vt.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add negovf"});
        vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add ones"});

        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 0;

        // Reset state
        #12;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst sum", 64'(sum), 64'd0);
        chk("rst cout/ovf", 64'({cout, ovf}), 64'd0);
        #5 rst = 1'b0;
        #1;
        chk("rel in_ready", 64'(in_ready), 64'd1);
        chk("rel out_valid", 64'(out_valid), 64'd0);

        // Spec vector table
        foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
                              vt[i].es, vt[i].ec, vt[i].eo, vt[i].nm);

        // Backpressure: hold result 5 cycles while inputs churn
        @(negedge clk);
        a = 16'h0A0B; b = 16'h0102; cin = 0; sub = 0; in_valid = 1; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("bp latency", 64'(cyc), 64'(N));
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0B0D ||
                cout !== 1'b0 || ovf !== 1'b0) flag = 1'b1;
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        chk("bp stable", 64'(flag), 64'd0);
        chk("bp sum", 64'(sum), 64'h0B0D);
        in_valid = 1; out_ready = 1;   // in_valid high during result handshake
        @(negedge clk);
        chk("bp out_valid", 64'(out_valid), 64'd0);
        chk("bp in_ready", 64'(in_ready), 64'd1);
        chk("bp sum held", 64'(sum), 64'h0B0D);
        in_valid = 0;

        // Asynchronous reset while holding a result in DONE
        @(negedge clk);
        a = 16'h8000; b = 16'h8001; cin = 0; sub = 0; in_valid = 1; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("ar pre sum", 64'({sum, cout, ovf}), 64'({16'h0001, 1'b1, 1'b1}));
        #2 rst = 1'b1;
        #1;
        chk("ar sum", 64'(sum), 64'd0);
        chk("ar cout/ovf", 64'({cout, ovf}), 64'd0);
        chk("ar valid/ready", 64'({out_valid, in_ready}), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar rel ready", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1;

        // Reset two cycles into RUN
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr sum", 64'({sum, cout, ovf}), 64'd0);
        #4 rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) flag = 1'b1;
        end
        chk("mr no valid", 64'(flag), 64'd0);
        do_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "mr next");

        // NCHUNK = 1 instance
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; iv8 = 1; or8 = 1;
        chk("n1 in_ready", 64'(ir8), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 0;
        cyc = 0;
        while (!ov8 && cyc < 10) begin @(negedge clk); cyc++; end
        chk("n1 latency", 64'(cyc), 64'd1);
        chk("n1 result", 64'({sum8, cout8, ovf8}), 64'({8'h00, 1'b1, 1'b0}));
        @(negedge clk);
        chk("n1 after", 64'({ov8, ir8}), 64'b01);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rcn = 1'($urandom); rsb = 1'($urandom);
            if (i % 8 == 0) rb = 16'hFFFF;
            model(W, longint'(ra), longint'(rb), rcn, rsb, rs, rc, ro);
            do_op(ra, rb, rcn, rsb, 16'(rs), rc, ro, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
